// File: rtl/board_gpio_io.sv
// Board-side GPIO front end: switch synchronise/debounce/edge/IRQ path and
// registered LED drive with optional per-bit blink gating.
module board_gpio_io #(
  parameter int N_SW            = 16,
  parameter int N_LED           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int BLINK_DIV       = 2**22
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N_SW-1:0]  i_sw,
  output logic [N_SW-1:0]  o_sw_db,
  output logic [N_SW-1:0]  o_sw_rise,
  output logic [N_SW-1:0]  o_sw_fall,
  input  logic [N_SW-1:0]  i_irq_mask,
  input  logic [N_SW-1:0]  i_irq_clr,
  output logic [N_SW-1:0]  o_irq_pending,
  output logic             o_irq,
  input  logic [N_LED-1:0] i_gpio_out,
  input  logic [N_LED-1:0] i_led_blink_en,
  output logic [N_LED-1:0] o_led
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [N_SW-1:0]  sync_p0 [SYNC_STAGES];
  logic [N_SW-1:0]  sw_s_p0;
  logic [CNT_W-1:0] db_cnt_p1 [N_SW];
  logic [N_SW-1:0]  db_flip;
  logic [N_SW-1:0]  pend_nxt;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;

  assign sw_s_p0 = sync_p0[SYNC_STAGES-1];

  // Stage p0: synchroniser chain on the raw pins
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_p0[k] <= '0;
    end else begin
      sync_p0[0] <= i_sw;
      for (int k = 1; k < SYNC_STAGES; k++) sync_p0[k] <= sync_p0[k-1];
    end
  end

  // A channel flips once it has disagreed for DEBOUNCE_CYCLES consecutive cycles
  always_comb begin
    db_flip = '0;
    for (int i = 0; i < N_SW; i++)
      db_flip[i] = (sw_s_p0[i] != o_sw_db[i]) && (db_cnt_p1[i] == CNT_LAST);
  end

  // Stage p1: debounce counters, debounced level and edge pulses
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < N_SW; i++) db_cnt_p1[i] <= '0;
      o_sw_db   <= '0;
      o_sw_rise <= '0;
      o_sw_fall <= '0;
    end else begin
      for (int i = 0; i < N_SW; i++) begin
        if ((sw_s_p0[i] == o_sw_db[i]) || db_flip[i])
          db_cnt_p1[i] <= '0;
        else
          db_cnt_p1[i] <= db_cnt_p1[i] + CNT_W'(1);
      end
      o_sw_db   <= o_sw_db ^ db_flip;
      o_sw_rise <= db_flip & ~o_sw_db;
      o_sw_fall <= db_flip & o_sw_db;
    end
  end

  // Set beats clear; a masked-off edge is simply dropped
  assign pend_nxt = (o_irq_pending & ~i_irq_clr) | ((o_sw_rise | o_sw_fall) & i_irq_mask);

  // Stage p2: sticky pending bits and their OR, updated together
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_irq_pending <= '0;
      o_irq         <= 1'b0;
    end else begin
      o_irq_pending <= pend_nxt;
      o_irq         <= |pend_nxt;
    end
  end

  // Blink phase generator and registered LED drive
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      o_led       <= '0;
    end else begin
      if (blink_cnt == BLK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLK_W'(1);
      end
      o_led <= i_gpio_out & (~i_led_blink_en | {N_LED{blink_phase}});
    end
  end

endmodule

// File: tb/tb_board_gpio_io.sv
// Self-checking bench for board_gpio_io: hand-computed vectors and a cycle
// reference model checked on every clock.
module tb_board_gpio_io;

  localparam int DC = 4;
  localparam int BD = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw = '0, mask = '0, clr = '0, gpio = '0, blink = '0;
  logic [15:0] sw_db, sw_rise, sw_fall, pend, led;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  board_gpio_io #(
    .N_SW(16), .N_LED(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DC), .BLINK_DIV(BD)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_sw(sw),
    .o_sw_db(sw_db), .o_sw_rise(sw_rise), .o_sw_fall(sw_fall),
    .i_irq_mask(mask), .i_irq_clr(clr),
    .o_irq_pending(pend), .o_irq(irq),
    .i_gpio_out(gpio), .i_led_blink_en(blink), .o_led(led)
  );

  always #5 clk = ~clk;

  // Reference model state: pin history, disagreement streaks, outputs
  logic [15:0] pin_hist [2];
  int          streak [16];
  logic [15:0] m_db, m_rise, m_fall, m_pend, m_led;
  logic        m_irq, m_phase;
  int          m_bcnt;

  task automatic model_edge();
    logic [15:0] s, ndb, nr, nf, np;
    if (rst) begin
      pin_hist[0] = '0; pin_hist[1] = '0;
      for (int i = 0; i < 16; i++) streak[i] = 0;
      m_db = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_irq = 1'b0;
      m_led = '0; m_bcnt = 0; m_phase = 1'b0;
    end else begin
      s   = pin_hist[1];
      ndb = m_db; nr = '0; nf = '0;
      for (int i = 0; i < 16; i++) begin
        if (s[i] != m_db[i]) begin
          streak[i] = streak[i] + 1;
          if (streak[i] == DC) begin
            ndb[i] = s[i];
            nr[i]  = s[i];
            nf[i]  = ~s[i];
            streak[i] = 0;
          end
        end else begin
          streak[i] = 0;
        end
      end
      np = (m_pend & ~clr) | ((m_rise | m_fall) & mask);
      m_led = gpio & (~blink | {16{m_phase}});
      m_bcnt = (m_bcnt + 1) % BD;
      if (m_bcnt == 0) m_phase = ~m_phase;
      pin_hist[1] = pin_hist[0];
      pin_hist[0] = sw;
      m_db = ndb; m_rise = nr; m_fall = nf; m_pend = np; m_irq = |np;
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model_db",   sw_db,   m_db);
    check("model_rise", sw_rise, m_rise);
    check("model_fall", sw_fall, m_fall);
    check("model_pend", pend,    m_pend);
    check("model_irq",  {15'd0, irq}, {15'd0, m_irq});
    check("model_led",  led,     m_led);
    check("rise_fall_excl", sw_rise & sw_fall, 16'h0000);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  typedef struct {
    logic [15:0] sw;
    int          n;
    logic [15:0] db, rise, fall;
  } db_vec_t;

  typedef struct {
    logic [15:0] gpio;
    logic [15:0] led;
  } led_vec_t;

  db_vec_t  dbv [6];
  led_vec_t ledv [4];

  initial begin
    dbv[0] = '{16'h0001, 5, 16'h0000, 16'h0000, 16'h0000};
    dbv[1] = '{16'h0001, 1, 16'h0001, 16'h0001, 16'h0000};
    dbv[2] = '{16'h0001, 1, 16'h0001, 16'h0000, 16'h0000};
    dbv[3] = '{16'h0000, 5, 16'h0001, 16'h0000, 16'h0000};
    dbv[4] = '{16'h0000, 1, 16'h0000, 16'h0000, 16'h0001};
    dbv[5] = '{16'h0000, 1, 16'h0000, 16'h0000, 16'h0000};
    ledv[0] = '{16'hA5A5, 16'hA5A5};
    ledv[1] = '{16'hFFFF, 16'hFFFF};
    ledv[2] = '{16'h0000, 16'h0000};
    ledv[3] = '{16'h1234, 16'h1234};

    // Reset state
    gpio = 16'hFFFF;
    ticks(2);
    check("reset_db",   sw_db, 16'h0000);
    check("reset_pend", pend,  16'h0000);
    check("reset_led",  led,   16'h0000);
    rst = 1'b0;
    gpio = '0;
    ticks(2);

    // Debounce latency and edge pulses on channel 0
    foreach (dbv[v]) begin
      sw = dbv[v].sw;
      ticks(dbv[v].n);
      check($sformatf("tbl_db%0d", v),   sw_db,   dbv[v].db);
      check($sformatf("tbl_rise%0d", v), sw_rise, dbv[v].rise);
      check($sformatf("tbl_fall%0d", v), sw_fall, dbv[v].fall);
    end

    // Short glitches on channel 3 are rejected
    for (int r = 0; r < 10; r++) begin
      sw = 16'h0008;
      for (int k = 0; k < 3; k++) begin
        tick();
        check("glitch_db", sw_db, 16'h0000);
        check("glitch_pulse", sw_rise | sw_fall, 16'h0000);
      end
      sw = 16'h0000;
      for (int k = 0; k < 3; k++) begin
        tick();
        check("glitch_db", sw_db, 16'h0000);
        check("glitch_pulse", sw_rise | sw_fall, 16'h0000);
      end
    end
    ticks(4);

    // IRQ set, set-beats-clear, then clear
    mask = 16'h0020;
    sw = 16'h0020;
    ticks(6);
    check("irq_rise5", sw_rise, 16'h0020);
    tick();
    check("irq_pend_set", pend, 16'h0020);
    check("irq_out_set", {15'd0, irq}, 16'h0001);
    sw = 16'h0000;
    ticks(6);
    check("irq_fall5", sw_fall, 16'h0020);
    clr = 16'h0020;
    tick();
    check("irq_set_wins", pend, 16'h0020);
    tick();
    clr = 16'h0000;
    check("irq_cleared", pend, 16'h0000);
    check("irq_out_clr", {15'd0, irq}, 16'h0000);

    // Masked-off channel 7 loses its edge
    sw = 16'h0080;
    ticks(7);
    check("mask_off_db7", sw_db, 16'h0080);
    check("mask_off_pend", pend, 16'h0000);
    mask = 16'h00A0;
    ticks(3);
    check("mask_late_pend", pend, 16'h0000);
    mask = 16'h0000;
    sw = 16'h0000;
    ticks(8);

    // LED drive, no blink
    foreach (ledv[v]) begin
      gpio = ledv[v].gpio;
      tick();
      check($sformatf("led_tbl%0d", v), led, ledv[v].led);
    end

    // Blink phase from a fresh reset
    gpio = 16'hFFFF;
    blink = 16'h0001;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("blink_led", led, 16'hFFFE | 16'(((k - 1) / 3) % 2));
    end
    blink = 16'h0000;

    // Reset mid-count, switch held through reset
    mask = 16'h0004;
    sw = 16'h0004;
    ticks(4);
    check("midcnt_db", sw_db, 16'h0000);
    rst = 1'b1;
    tick();
    check("rst_db",   sw_db,   16'h0000);
    check("rst_rise", sw_rise, 16'h0000);
    check("rst_pend", pend,    16'h0000);
    check("rst_led",  led,     16'h0000);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("post_rst_norise", sw_rise, 16'h0000);
    end
    tick();
    check("post_rst_rise", sw_rise, 16'h0004);
    tick();
    check("post_rst_pend", pend, 16'h0004);
    check("post_rst_irq", {15'd0, irq}, 16'h0001);

    // Randomised traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      sw   = sw ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      clr  = 16'($urandom) & 16'($urandom) & 16'($urandom);
      gpio = 16'($urandom);
      if (c % 50 == 0) mask = 16'($urandom);
      if (c % 20 == 0) blink = 16'($urandom);
      rst  = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
